// File: rtl/rf_dump_reader.sv
// Purpose   : walks a contiguous (wrapping) range of the register file through one
//             shared read port and streams each word out as an addressed dump beat.
// Latency   : first read 1 cycle after accepted start; one beat per 3 cycles when unstalled.
// Backpress : dump_ready=0 holds the beat in PRESENT with data/addr/last frozen; rf_busy=0
//             is required before a read issues (the datapath always wins the port).
// Ports     : clock/reset_n (async active-low); start/abort/first_addr/last_addr control;
//             rf_read_enabled/rf_read_addr/rf_read_data RF port; dump_valid/dump_ready/
//             dump_data/dump_addr/dump_last beat stream; busy status; done completion pulse.
module rf_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic                  rf_busy,
  output logic                  rf_read_enabled,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic                  dump_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_PRESENT = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_cur;
  logic [ADDR_WIDTH-1:0] r_last;
  logic [DATA_WIDTH-1:0] r_dump_data;
  logic [ADDR_WIDTH-1:0] r_dump_addr;
  logic                  r_dump_last;
  logic                  r_done;

  logic w_rd_en;
  logic w_accept;
  logic w_capture;
  logic w_hs;

  // Abort outranks every other decision in a non-IDLE state, including a
  // same-cycle read issue or beat handshake.
  always_comb begin
    w_next    = r_state;
    w_rd_en   = 1'b0;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_hs      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (!rf_busy) begin
          w_rd_en = 1'b1;
          w_next  = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          w_next = S_IDLE;
        end else begin
          w_capture = 1'b1;
          w_next    = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (dump_ready) begin
          w_hs   = 1'b1;
          w_next = r_dump_last ? S_IDLE : S_ISSUE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cur       <= '0;
      r_last      <= '0;
      r_dump_data <= '0;
      r_dump_addr <= '0;
      r_dump_last <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cur  <= first_addr;
        r_last <= last_addr;
      end else if (w_hs && !r_dump_last) begin
        // Natural ADDR_WIDTH overflow gives the wrap from the top register to 0.
        r_cur <= r_cur + 1'b1;
      end
      if (w_capture) begin
        r_dump_data <= rf_read_data;
        r_dump_addr <= r_cur;
        r_dump_last <= (r_cur == r_last);
      end
      r_done <= w_hs && r_dump_last;
    end
  end

  assign rf_read_enabled = w_rd_en;
  assign rf_read_addr    = (r_state != S_IDLE) ? r_cur : '0;
  assign dump_valid      = (r_state == S_PRESENT);
  assign dump_data       = r_dump_data;
  assign dump_addr       = r_dump_addr;
  assign dump_last       = r_dump_last;
  assign busy            = (r_state != S_IDLE);
  assign done            = r_done;

endmodule

// File: tb/tb_rf_dump_reader.sv
module tb_rf_dump_reader;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic          rf_busy = 1'b0;
  logic          rf_read_enabled;
  logic [AW-1:0] rf_read_addr;
  logic [DW-1:0] rf_read_data = '0;
  logic          dump_valid;
  logic          dump_ready = 1'b0;
  logic [DW-1:0] dump_data;
  logic [AW-1:0] dump_addr;
  logic          dump_last;
  logic          busy;
  logic          done;

  rf_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .first_addr      (first_addr),
    .last_addr       (last_addr),
    .rf_busy         (rf_busy),
    .rf_read_enabled (rf_read_enabled),
    .rf_read_addr    (rf_read_addr),
    .rf_read_data    (rf_read_data),
    .dump_valid      (dump_valid),
    .dump_ready      (dump_ready),
    .dump_data       (dump_data),
    .dump_addr       (dump_addr),
    .dump_last       (dump_last),
    .busy            (busy),
    .done            (done)
  );

  always #5 clock = ~clock;

  // Register file: data appears the cycle after the read strobe.
  logic [DW-1:0] rf_mem [NREG];
  always @(posedge clock) begin
    if (rf_read_enabled) rf_read_data <= rf_mem[rf_read_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the expected beat list is the range itself.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;
  beat_t exp_q[$];

  function automatic int beat_count(input logic [AW-1:0] f, input logic [AW-1:0] l);
    int diff;
    diff = (int'(l) - int'(f) + NREG) % NREG;
    return diff + 1;
  endfunction

  task automatic push_expected(input logic [AW-1:0] f, input logic [AW-1:0] l);
    int    n;
    int    a;
    beat_t b;
    n = beat_count(f, l);
    for (int k = 0; k < n; k++) begin
      a   = (int'(f) + k) % NREG;
      b.a = AW'(a);
      b.d = rf_mem[a];
      b.l = (k == n - 1);
      exp_q.push_back(b);
    end
  endtask

  // Stream monitor: content, stall stability, port rules and the done pulse.
  logic          prev_stall = 1'b0;
  logic          prev_rd = 1'b0;
  logic          exp_done = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic [AW-1:0] prev_a = '0;
  logic          prev_l = 1'b0;

  always @(negedge clock) begin
    beat_t b;
    if (!reset_n) begin
      exp_done   = 1'b0;
      prev_stall = 1'b0;
      prev_rd    = 1'b0;
    end else begin
      check("done_pulse", done, exp_done);
      exp_done = 1'b0;
      check("rd_while_rf_busy", rf_read_enabled & rf_busy, 0);
      check("rd_back_to_back", rf_read_enabled & prev_rd, 0);
      check("rd_while_presenting", rf_read_enabled & dump_valid, 0);
      if (prev_stall) begin
        check("stall_valid", dump_valid, 1);
        check("stall_data", dump_data, prev_d);
        check("stall_addr", dump_addr, prev_a);
        check("stall_last", dump_last, prev_l);
      end
      if (dump_valid && dump_ready && !abort) begin
        if (exp_q.size() == 0) begin
          check("beat_extra", exp_q.size(), 1);
        end else begin
          b = exp_q.pop_front();
          check("beat_addr", dump_addr, b.a);
          check("beat_data", dump_data, b.d);
          check("beat_last", dump_last, b.l);
          exp_done = b.l;
        end
      end
      prev_stall = dump_valid && !dump_ready && !abort;
      prev_d     = dump_data;
      prev_a     = dump_addr;
      prev_l     = dump_last;
      prev_rd    = rf_read_enabled;
    end
  end

  typedef struct {
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    int            busy_len;
    int            stall_beat;
    int            stall_len;
    int            exp_beats;
    int            exp_cycles;
    logic [DW-1:0] exp_d0;
  } vec_t;

  task automatic run_dump(input vec_t v);
    int            hs;
    int            done_c;
    int            s0;
    logic [DW-1:0] d0;
    hs     = 0;
    done_c = -1;
    d0     = '0;
    s0     = v.busy_len + 3 * (v.stall_beat + 1);
    @(posedge clock); #1;
    first_addr = v.first;
    last_addr  = v.last;
    start      = 1'b1;
    dump_ready = 1'b1;
    rf_busy    = (v.busy_len > 0);
    push_expected(v.first, v.last);
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      rf_busy    = (c <= v.busy_len);
      dump_ready = !(v.stall_len > 0 && c >= s0 && c < s0 + v.stall_len);
      @(negedge clock);
      if (c <= v.busy_len) check("rd_held_by_rf_busy", rf_read_enabled, 0);
      if (c == v.busy_len + 1) begin
        check("first_rd_strobe", rf_read_enabled, 1);
        check("first_rd_addr", rf_read_addr, v.first);
      end
      if (dump_valid && dump_ready) begin
        if (hs == 0) d0 = dump_data;
        hs++;
      end
      if (done) begin
        done_c = c;
        check("busy_at_done", busy, 0);
        break;
      end
      @(posedge clock); #1;
    end
    check("dump_cycles", done_c, v.exp_cycles);
    check("dump_beats", hs, v.exp_beats);
    check("dump_first_data", d0, v.exp_d0);
    check("model_drained", exp_q.size(), 0);
    rf_busy    = 1'b0;
    dump_ready = 1'b1;
  endtask

  vec_t tbl[9];

  initial begin
    int            hs;
    logic          sent;
    logic [AW-1:0] rf_f;
    logic [AW-1:0] rf_l;
    int            done_seen;

    // cycles to done = 3*beats + 1 + rf_busy cycles + stall cycles
    tbl[0] = '{5'd2,  5'd5,  0, 0, 0, 4,  13, 32'h11111111};
    tbl[1] = '{5'd30, 5'd1,  0, 0, 0, 4,  13, 32'h0000000E};
    tbl[2] = '{5'd2,  5'd5,  0, 1, 5, 4,  18, 32'h11111111};
    tbl[3] = '{5'd2,  5'd5,  4, 0, 0, 4,  17, 32'h11111111};
    tbl[4] = '{5'd7,  5'd7,  0, 0, 0, 1,  4,  32'h66666666};
    tbl[5] = '{5'd0,  5'd31, 0, 0, 0, 32, 97, 32'hDEADBEEF};
    tbl[6] = '{5'd31, 5'd0,  0, 0, 0, 2,  7,  32'hDEADBEEF};
    tbl[7] = '{5'd10, 5'd9,  0, 0, 0, 32, 97, 32'h99999999};
    tbl[8] = '{5'd0,  5'd0,  0, 0, 0, 1,  4,  32'hDEADBEEF};

    for (int n = 0; n < NREG; n++) rf_mem[n] = 32'(n - 1) * 32'h11111111;
    rf_mem[30] = 32'h0000000E;
    rf_mem[31] = 32'hDEADBEEF;
    rf_mem[0]  = 32'hDEADBEEF;
    rf_mem[1]  = 32'h00000000;

    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_valid", dump_valid, 0);
    check("rst_rd_en", rf_read_enabled, 0);
    check("rst_rd_addr", rf_read_addr, 0);
    check("rst_done", done, 0);
    check("rst_data", dump_data, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    dump_ready = 1'b1;

    for (int i = 0; i < 9; i++) run_dump(tbl[i]);

    // Abort after the second handshake of a full dump; a mid-dump start is ignored.
    @(posedge clock); #1;
    first_addr = 5'd0; last_addr = 5'd31; start = 1'b1; dump_ready = 1'b1;
    push_expected(5'd0, 5'd31);
    @(posedge clock); #1;
    start = 1'b0;
    hs = 0; sent = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (dump_valid && dump_ready) hs++;
      if (hs >= 2) break;
      @(posedge clock); #1;
      start = (hs == 1) && !sent;
      if (start) begin
        sent = 1'b1; first_addr = 5'd20; last_addr = 5'd21;
      end
    end
    check("abort_reached_beat2", hs, 2);
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("abort_busy", busy, 0);
    check("abort_valid", dump_valid, 0);
    check("abort_rd_en", rf_read_enabled, 0);
    repeat (4) @(posedge clock);
    run_dump('{5'd3, 5'd4, 0, 0, 0, 2, 7, 32'h22222222});

    // Abort while a single last beat is presented with dump_ready=1: no done.
    @(posedge clock); #1;
    first_addr = 5'd5; last_addr = 5'd5; start = 1'b1;
    push_expected(5'd5, 5'd5);
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1; abort = 1'b1;
    @(negedge clock);
    check("inflight_valid", dump_valid, 1);
    @(posedge clock); #1; abort = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("inflight_drop_valid", dump_valid, 0);
    check("inflight_drop_busy", busy, 0);
    repeat (3) @(posedge clock);

    // start together with abort in IDLE does nothing.
    @(posedge clock); #1;
    first_addr = 5'd1; last_addr = 5'd2; start = 1'b1; abort = 1'b1;
    @(posedge clock); #1; start = 1'b0; abort = 1'b0;
    @(negedge clock);
    check("start_abort_idle", busy, 0);
    repeat (5) @(posedge clock);

    // Asynchronous reset mid-dump.
    @(posedge clock); #1;
    first_addr = 5'd0; last_addr = 5'd31; start = 1'b1;
    push_expected(5'd0, 5'd31);
    @(posedge clock); #1; start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", dump_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_rd_en", rf_read_enabled, 0);
    check("arst_rd_addr", rf_read_addr, 0);
    check("arst_data", dump_data, 0);
    check("arst_addr", dump_addr, 0);
    check("arst_last", dump_last, 0);
    check("arst_done", done, 0);
    exp_q.delete();
    @(negedge clock); #2;
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_idle", busy, 0);
    run_dump(tbl[4]);

    // Randomized dumps with random RF contents, rf_busy and dump_ready.
    for (int i = 0; i < 6; i++) begin
      for (int n = 0; n < NREG; n++) rf_mem[n] = $urandom;
      rf_f = AW'($urandom_range(0, NREG - 1));
      rf_l = AW'($urandom_range(0, NREG - 1));
      @(posedge clock); #1;
      first_addr = rf_f; last_addr = rf_l; start = 1'b1;
      push_expected(rf_f, rf_l);
      @(posedge clock); #1; start = 1'b0;
      hs = 0; done_seen = 0;
      for (int c = 0; c < 1000; c++) begin
        rf_busy    = ($urandom_range(0, 3) == 0);
        dump_ready = ($urandom_range(0, 3) != 0);
        @(negedge clock);
        if (dump_valid && dump_ready) hs++;
        if (done) begin
          done_seen = 1;
          break;
        end
        @(posedge clock); #1;
      end
      check("rand_done_seen", done_seen, 1);
      check("rand_beats", hs, beat_count(rf_f, rf_l));
      check("rand_model_drained", exp_q.size(), 0);
      rf_busy = 1'b0; dump_ready = 1'b1;
    end

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected $finish");
    $fatal(1);
  end

endmodule
